trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer for the RV32 core; it drives the special-CSR write port of the CSR file. It detects synchronous exceptions, enabled interrupts and `mret` at the EX boundary. For traps it commits `mepc`, `mcause` and `mstatus`; for `mret` it restores `mstatus`. It then issues a one-cycle PC redirect and holds the pipeline flushed for the whole sequence.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction; exception and mret flags are qualified by it
- ex_pc  in  32  PC of the EX instruction
- ex_illegal / ex_ebreak / ex_ecall / ex_mret  in  1 each  decoded EX instruction events
- int_ok  in  1  pipeline is at an interruptible boundary this cycle
- int_pc  in  32  PC of the next not-yet-executed instruction
- irq_ext / irq_sw / irq_timer  in  1 each  level-sensitive pending interrupt lines
- csr_mstatus, csr_mepc, csr_mtvec, csr_mie  in  32 each  current CSR values
- EX_mepc_vld, EX_mcause_vld, EX_mstatus_vld  out  1 each  special-CSR write strobes
- EX_mepc, EX_mcause, EX_mstatus  out  32 each  special-CSR write data
- trap_busy  out  1  sequence in progress; pipeline stalls and flushes IF/ID/EX
- redirect_vld  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target

## Operation
- FSM states:
  - IDLE.
  - TRAP_WR: writes mepc, mcause and mstatus.
  - MRET_WR: writes mstatus only.
  - JUMP: drives the redirect.
- Event priority in IDLE:
  - ex_valid exceptions first: illegal (cause 2), then ebreak (3), then ecall (11).
  - ex_mret next.
  - Interrupts last, and only when int_ok=1 and mstatus[3] (MIE)=1.
- Interrupt priority:
  - irq_ext with mie[11]: cause 0x8000000B.
  - irq_sw with mie[3]: cause 0x80000003.
  - irq_timer with mie[7]: cause 0x80000007.
- Captured mepc: ex_pc for exceptions, int_pc for interrupts.
- Trap mstatus value:
  - MPIE (bit 7) takes the old MIE.
  - MIE is cleared.
  - MPP (bits 12:11) is set to 2'b11.
  - All other bits pass through.
- Mret mstatus value:
  - MIE takes MPIE.
  - MPIE is set to 1.
  - MPP stays 2'b11.
- Redirect target:
  - Trap: {csr_mtvec[31:2],2'b00}.
  - Mret: csr_mepc, sampled in JUMP.
- Transitions:
  - IDLE goes to TRAP_WR or MRET_WR on an event, otherwise stays.
  - Either *_WR state goes to JUMP.
  - JUMP goes to IDLE.
- All event inputs are ignored outside IDLE. A pending irq is re-evaluated on the return to IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Cycle N: event sampled in IDLE.
- Cycle N+1, *_WR state:
  - The relevant *_vld strobes are high for exactly one cycle with their data.
  - trap_busy=1.
- Cycle N+2, JUMP:
  - redirect_vld=1 for one cycle with redirect_pc.
  - trap_busy=1.
- Cycle N+3: IDLE, trap_busy=0.
- The earliest next event is sampled at N+3. Back-to-back traps are 3 cycles apart.
- Updated CSR values are visible on csr_* inputs from N+2. The JUMP state relies on this.
- Strobes are 0 whenever not in a *_WR state. Data holds its last value.
- rst in any state:
  - Next cycle is IDLE.
  - All strobes, redirect_vld and trap_busy are 0.
  - No partial CSR write survives beyond the cycle already driven.
- A simultaneous exception and interrupt always takes the exception. The interrupt stays pending.

## Configuration
- VECTORED_MTVEC_EN defined:
  - If csr_mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc = {mtvec[31:2],2'b00} + 4*cause[4:0].
  - Exceptions and mtvec mode 00 use the base address.
  - Mode values 10 and 11 are treated as 00.
- Macro not defined: mtvec[1:0] is ignored and every trap goes to the base address.

## Structure
- Add to inc/defines.v:
  - Cause codes (CAUSE_ILLEGAL, CAUSE_EBREAK, CAUSE_ECALL_M, CAUSE_INT_MSI/MTI/MEI).
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - FSM state encodings.
- One combinational sub-module, trap_cause_enc:
  - Applies the priority rules.
  - Produces take_trap, take_mret, cause[31:0] and the captured PC.
- The FSM, strobe and redirect registers live in trap_ctrl.

## Test plan
- ecall:
  - Stimulus: ex_pc=0x40, mstatus=0x8, mtvec=0x100.
  - Response: N+1 mepc=0x40, mcause=11, mstatus=0x1880; N+2 redirect_pc=0x100; busy for 2 cycles.
- Timer interrupt:
  - Stimulus: mstatus=0x8, mie=0x80, irq_timer=1, int_ok=1, int_pc=0x200.
  - Response: mcause=0x80000007, mepc=0x200, redirect 0x100.
  - With VECTORED_MTVEC_EN and mtvec=0x101: redirect 0x11C.
- mret:
  - Stimulus: mstatus=0x1880, mepc=0x44.
  - Response: only EX_mstatus_vld, with mstatus=0x1888; redirect_pc=0x44.
- Masked interrupt:
  - Stimulus: mstatus=0x0, irq_ext=1, mie=0x800.
  - Response: no strobes, trap_busy stays 0.
  - Then set MIE: cause 0x8000000B.
- Exception wins over interrupt:
  - Stimulus: ecall and irq_ext in the same cycle.
  - Response: mcause=11.
  - The interrupt is taken 3 cycles later, with mepc=int_pc.
- Reset:
  - Stimulus: rst asserted in TRAP_WR.
  - Response: next cycle all outputs 0 and no redirect; a new ecall after reset completes normally.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared constants, FSM state type and mstatus update helpers for the trap sequencer.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StTrapWr, StMretWr, StJump} trap_state_e;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_INT_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_INT_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_INT_MEI = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIE_MSIE = 3;
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    v[MSTATUS_MPIE] = old[MSTATUS_MIE];
    v[MSTATUS_MIE] = 1'b0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    v[MSTATUS_MIE] = old[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap sequencer bundle: EX-stage events, interrupt lines, CSR read values,
// special-CSR write port and PC redirect. master = trap_ctrl side.
interface trap_ctrl_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_illegal;
  logic        ex_ebreak;
  logic        ex_ecall;
  logic        ex_mret;
  logic        int_ok;
  logic [31:0] int_pc;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_timer;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mie;
  logic        EX_mepc_vld;
  logic        EX_mcause_vld;
  logic        EX_mstatus_vld;
  logic [31:0] EX_mepc;
  logic [31:0] EX_mcause;
  logic [31:0] EX_mstatus;
  logic        trap_busy;
  logic        redirect_vld;
  logic [31:0] redirect_pc;

  modport master (
    input  ex_valid, ex_pc, ex_illegal, ex_ebreak, ex_ecall, ex_mret,
    input  int_ok, int_pc, irq_ext, irq_sw, irq_timer,
    input  csr_mstatus, csr_mepc, csr_mtvec, csr_mie,
    output EX_mepc_vld, EX_mcause_vld, EX_mstatus_vld,
    output EX_mepc, EX_mcause, EX_mstatus,
    output trap_busy, redirect_vld, redirect_pc
  );

  modport slave (
    output ex_valid, ex_pc, ex_illegal, ex_ebreak, ex_ecall, ex_mret,
    output int_ok, int_pc, irq_ext, irq_sw, irq_timer,
    output csr_mstatus, csr_mepc, csr_mtvec, csr_mie,
    input  EX_mepc_vld, EX_mcause_vld, EX_mstatus_vld,
    input  EX_mepc, EX_mcause, EX_mstatus,
    input  trap_busy, redirect_vld, redirect_pc
  );
endinterface

// File: rtl/trap_cause_enc.sv
// Combinational event priority encoder: exceptions > mret > enabled interrupts.
module trap_cause_enc
  import trap_ctrl_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_illegal,
  input  logic        ex_ebreak,
  input  logic        ex_ecall,
  input  logic        ex_mret,
  input  logic [31:0] ex_pc,
  input  logic        int_ok,
  input  logic [31:0] int_pc,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  output logic        take_trap,
  output logic        take_mret,
  output logic [31:0] cause,
  output logic [31:0] trap_pc
);

  logic exc;
  logic mret_ev;
  logic ext_en;
  logic sw_en;
  logic tmr_en;
  logic irq_take;

  assign exc      = ex_valid & (ex_illegal | ex_ebreak | ex_ecall);
  assign mret_ev  = ex_valid & ex_mret;
  assign ext_en   = irq_ext & mie[MIE_MEIE];
  assign sw_en    = irq_sw & mie[MIE_MSIE];
  assign tmr_en   = irq_timer & mie[MIE_MTIE];
  assign irq_take = int_ok & mstatus_mie & (ext_en | sw_en | tmr_en);

  assign take_trap = exc | (irq_take & ~mret_ev);
  assign take_mret = mret_ev & ~exc;
  assign trap_pc   = exc ? ex_pc : int_pc;

  always_comb begin
    cause = CAUSE_INT_MTI;
    if (ex_valid && ex_illegal)     cause = CAUSE_ILLEGAL;
    else if (ex_valid && ex_ebreak) cause = CAUSE_EBREAK;
    else if (ex_valid && ex_ecall)  cause = CAUSE_ECALL_M;
    else if (ext_en)                cause = CAUSE_INT_MEI;
    else if (sw_en)                 cause = CAUSE_INT_MSI;
  end

  logic unused_mie;
  assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: IDLE -> TRAP_WR/MRET_WR -> JUMP -> IDLE, all outputs registered.
// Optional VECTORED_MTVEC_EN: vectored interrupt targets when mtvec mode is 01.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  trap_ctrl_if.master  bus
);

  trap_state_e state_q, state_d;
  logic        take_trap;
  logic        take_mret;
  logic [31:0] cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_target;

  logic        mepc_vld_q, mepc_vld_d;
  logic        mcause_vld_q, mcause_vld_d;
  logic        mstatus_vld_q, mstatus_vld_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic        busy_q, busy_d;
  logic        redirect_vld_q, redirect_vld_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  trap_cause_enc u_enc (
    .ex_valid    (bus.ex_valid),
    .ex_illegal  (bus.ex_illegal),
    .ex_ebreak   (bus.ex_ebreak),
    .ex_ecall    (bus.ex_ecall),
    .ex_mret     (bus.ex_mret),
    .ex_pc       (bus.ex_pc),
    .int_ok      (bus.int_ok),
    .int_pc      (bus.int_pc),
    .irq_ext     (bus.irq_ext),
    .irq_sw      (bus.irq_sw),
    .irq_timer   (bus.irq_timer),
    .mstatus_mie (bus.csr_mstatus[MSTATUS_MIE]),
    .mie         (bus.csr_mie),
    .take_trap   (take_trap),
    .take_mret   (take_mret),
    .cause       (cause),
    .trap_pc     (trap_pc)
  );

  // mcause_q still holds the trap cause while in TRAP_WR, so it drives vectoring.
  always_comb begin
    trap_target = {bus.csr_mtvec[31:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
    if (mcause_q[31] && bus.csr_mtvec[1:0] == 2'b01) begin
      trap_target = trap_target + {25'd0, mcause_q[4:0], 2'b00};
    end
`endif
  end

`ifndef VECTORED_MTVEC_EN
  logic unused_mtvec;
  assign unused_mtvec = ^bus.csr_mtvec[1:0];
`endif

  always_comb begin
    state_d        = state_q;
    mepc_vld_d     = 1'b0;
    mcause_vld_d   = 1'b0;
    mstatus_vld_d  = 1'b0;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mstatus_d      = mstatus_q;
    redirect_vld_d = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    case (state_q)
      StIdle: begin
        if (take_trap) begin
          state_d       = StTrapWr;
          mepc_vld_d    = 1'b1;
          mcause_vld_d  = 1'b1;
          mstatus_vld_d = 1'b1;
          mepc_d        = trap_pc;
          mcause_d      = cause;
          mstatus_d     = trap_mstatus(bus.csr_mstatus);
        end else if (take_mret) begin
          state_d       = StMretWr;
          mstatus_vld_d = 1'b1;
          mstatus_d     = mret_mstatus(bus.csr_mstatus);
        end
      end
      StTrapWr: begin
        state_d        = StJump;
        redirect_vld_d = 1'b1;
        redirect_pc_d  = trap_target;
      end
      StMretWr: begin
        state_d        = StJump;
        redirect_vld_d = 1'b1;
        redirect_pc_d  = bus.csr_mepc;
      end
      StJump:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      mepc_vld_q     <= 1'b0;
      mcause_vld_q   <= 1'b0;
      mstatus_vld_q  <= 1'b0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mstatus_q      <= '0;
      busy_q         <= 1'b0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      mepc_vld_q     <= mepc_vld_d;
      mcause_vld_q   <= mcause_vld_d;
      mstatus_vld_q  <= mstatus_vld_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mstatus_q      <= mstatus_d;
      busy_q         <= busy_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign bus.EX_mepc_vld    = mepc_vld_q;
  assign bus.EX_mcause_vld  = mcause_vld_q;
  assign bus.EX_mstatus_vld = mstatus_vld_q;
  assign bus.EX_mepc        = mepc_q;
  assign bus.EX_mcause      = mcause_q;
  assign bus.EX_mstatus     = mstatus_q;
  assign bus.trap_busy      = busy_q;
  assign bus.redirect_vld   = redirect_vld_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed events push expected writes/redirects,
// a negedge monitor pops and compares whenever a strobe or redirect appears.
module tb_trap_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_redir;
    bit          ev;
    bit          cv;
    bit          sv;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] status;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input bit ev, input bit cv, input bit sv, input logic [31:0] epc,
                         input logic [31:0] cause, input logic [31:0] status);
    exp_t e;
    e = '{is_redir: 1'b0, ev: ev, cv: cv, sv: sv, epc: epc, cause: cause, status: status,
          pc: 32'd0};
    q.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] pc);
    exp_t e;
    e = '{is_redir: 1'b1, ev: 1'b0, cv: 1'b0, sv: 1'b0, epc: 32'd0, cause: 32'd0,
          status: 32'd0, pc: pc};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any strobe or redirect must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.EX_mepc_vld === 1'b1 || bus.EX_mcause_vld === 1'b1 ||
        bus.EX_mstatus_vld === 1'b1) begin
      if (q.size() == 0 || q[0].is_redir) begin
        chk("unexpected_write", {29'd0, bus.EX_mepc_vld, bus.EX_mcause_vld,
                                 bus.EX_mstatus_vld}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_strobes", {29'd0, bus.EX_mepc_vld, bus.EX_mcause_vld, bus.EX_mstatus_vld},
            {29'd0, e.ev, e.cv, e.sv});
        if (e.ev) chk("mepc", bus.EX_mepc, e.epc);
        if (e.cv) chk("mcause", bus.EX_mcause, e.cause);
        if (e.sv) chk("mstatus", bus.EX_mstatus, e.status);
      end
    end
    if (bus.redirect_vld === 1'b1) begin
      if (q.size() == 0 || !q[0].is_redir) begin
        chk("unexpected_redirect", {31'd0, bus.redirect_vld}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("redirect_pc", bus.redirect_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_events();
    bus.ex_valid  = 1'b0;
    bus.ex_illegal = 1'b0;
    bus.ex_ebreak = 1'b0;
    bus.ex_ecall  = 1'b0;
    bus.ex_mret   = 1'b0;
    bus.irq_ext   = 1'b0;
    bus.irq_sw    = 1'b0;
    bus.irq_timer = 1'b0;
    bus.int_ok    = 1'b0;
  endtask

  task automatic ecall(input logic [31:0] pc);
    bus.ex_valid = 1'b1;
    bus.ex_ecall = 1'b1;
    bus.ex_pc    = pc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_events();
    bus.ex_pc       = 32'd0;
    bus.int_pc      = 32'd0;
    bus.csr_mstatus = 32'd0;
    bus.csr_mepc    = 32'd0;
    bus.csr_mtvec   = 32'h100;
    bus.csr_mie     = 32'd0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.trap_busy}, 32'd0);
    chk("rst_redirect_vld", {31'd0, bus.redirect_vld}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_strobes", {29'd0, bus.EX_mepc_vld, bus.EX_mcause_vld, bus.EX_mstatus_vld}, 32'd0);
    chk("rst_mepc", bus.EX_mepc, 32'd0);
    chk("rst_mcause", bus.EX_mcause, 32'd0);
    chk("rst_mstatus", bus.EX_mstatus, 32'd0);
    rst = 1'b0;
    tick();

    // ecall
    bus.csr_mstatus = 32'h8;
    ecall(32'h40);
    push_wr(1, 1, 1, 32'h40, 32'd11, 32'h1880);
    push_redir(32'h100);
    tick();
    clear_events();
    chk("ecall_busy_wr", {31'd0, bus.trap_busy}, 32'd1);
    tick();
    chk("ecall_busy_jump", {31'd0, bus.trap_busy}, 32'd1);
    tick();
    chk("ecall_busy_idle", {31'd0, bus.trap_busy}, 32'd0);

    // timer interrupt, mtvec mode 01
    bus.csr_mtvec = 32'h101;
    bus.csr_mie   = 32'h80;
    bus.irq_timer = 1'b1;
    bus.int_ok    = 1'b1;
    bus.int_pc    = 32'h200;
    push_wr(1, 1, 1, 32'h200, 32'h8000_0007, 32'h1880);
`ifdef VECTORED_MTVEC_EN
    push_redir(32'h11C);
`else
    push_redir(32'h100);
`endif
    tick();
    clear_events();
    tick();
    tick();
    bus.csr_mtvec = 32'h100;

    // mret
    bus.csr_mstatus = 32'h1880;
    bus.csr_mepc    = 32'h44;
    bus.ex_valid    = 1'b1;
    bus.ex_mret     = 1'b1;
    push_wr(0, 0, 1, 32'd0, 32'd0, 32'h1888);
    push_redir(32'h44);
    tick();
    clear_events();
    tick();
    tick();
    chk("mret_busy_idle", {31'd0, bus.trap_busy}, 32'd0);

    // masked external interrupt, then unmasked
    bus.csr_mstatus = 32'h0;
    bus.csr_mie     = 32'h800;
    bus.irq_ext     = 1'b1;
    bus.int_ok      = 1'b1;
    bus.int_pc      = 32'h210;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("masked_busy", {31'd0, bus.trap_busy}, 32'd0);
    end
    bus.csr_mstatus = 32'h8;
    push_wr(1, 1, 1, 32'h210, 32'h8000_000B, 32'h1880);
    push_redir(32'h100);
    tick();
    clear_events();
    tick();
    tick();

    // exception beats interrupt; interrupt taken on return to IDLE
    bus.irq_ext = 1'b1;
    bus.int_ok  = 1'b1;
    bus.int_pc  = 32'h300;
    ecall(32'h80);
    push_wr(1, 1, 1, 32'h80, 32'd11, 32'h1880);
    push_redir(32'h100);
    push_wr(1, 1, 1, 32'h300, 32'h8000_000B, 32'h1880);
    push_redir(32'h100);
    tick();
    bus.ex_valid = 1'b0;
    bus.ex_ecall = 1'b0;
    tick();
    tick();
    chk("prio_idle_gap", {31'd0, bus.trap_busy}, 32'd0);
    tick();
    clear_events();
    chk("prio_irq_busy", {31'd0, bus.trap_busy}, 32'd1);
    tick();
    tick();

    // reset while in TRAP_WR
    ecall(32'h50);
    push_wr(1, 1, 1, 32'h50, 32'd11, 32'h1880);
    tick();
    clear_events();
    rst = 1'b1;
    tick();
    chk("rstwr_busy", {31'd0, bus.trap_busy}, 32'd0);
    chk("rstwr_redirect_vld", {31'd0, bus.redirect_vld}, 32'd0);
    chk("rstwr_strobes", {29'd0, bus.EX_mepc_vld, bus.EX_mcause_vld, bus.EX_mstatus_vld},
        32'd0);
    chk("rstwr_mepc", bus.EX_mepc, 32'd0);
    chk("rstwr_redirect_pc", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("rstwr_after_redirect", {31'd0, bus.redirect_vld}, 32'd0);
    chk("rstwr_after_busy", {31'd0, bus.trap_busy}, 32'd0);
    ecall(32'h60);
    push_wr(1, 1, 1, 32'h60, 32'd11, 32'h1880);
    push_redir(32'h100);
    tick();
    clear_events();
    tick();
    tick();
    tick();
    chk("drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
